fetch_unit: RTL

- Instruction fetch stage directly downstream of the 8-bit program counter.
- Samples the current PC, issues a request/acknowledge read to instruction memory and captures the returned byte.
- Presents the byte to decode with a valid/ready handshake and pulses the PC enable to advance it.
- Also handles flush (discarding in-flight fetches) and a memory timeout error.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_timeout_ctr.sv | 28 ++
 rtl/fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch stage.
package fetch_pkg;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        DROP = 3'd2,
        OUT  = 3'd3,
        ERR  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting on mem_ack; expire is high on the last allowed wait cycle.
module fetch_timeout_ctr
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expire = (count == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: samples the PC, reads instruction memory over req/ack and hands the byte to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_advance,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              mem_err,
    output fetch_state_t      state_dbg
);

    // Decode handshake: a transfer happens on a rising edge where instr_valid and
    // instr_ready are both high; instr_data/instr_pc stay frozen while valid waits for ready.

    fetch_state_t state;
    logic         waiting;
    logic         tmo_expire;

    // The wait counter runs only while a memory request is outstanding and reads zero on entry to REQ.
    assign waiting = (state == REQ) || (state == DROP);

    fetch_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clear (!waiting),
        .enable(waiting),
        .expire(tmo_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            pc_advance  <= 1'b0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
            mem_err     <= 1'b0;
        end else begin
            pc_advance <= 1'b0;
            case (state)
                IDLE: begin
                    if (run && !flush) begin
                        mem_addr <= pc_in;
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            instr_data  <= mem_rdata;
                            instr_pc    <= mem_addr;
                            instr_valid <= 1'b1;
                            pc_advance  <= 1'b1;
                            state       <= OUT;
                        end
                    end else if (tmo_expire) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        state   <= ERR;
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    // The memory still owes a reply; wait for it so the bus is left idle.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if (tmo_expire) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        state   <= ERR;
                    end
                end
                OUT: begin
                    if (flush) begin
                        instr_valid <= 1'b0;
                        state       <= IDLE;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (run) begin
                            mem_addr <= pc_in;
                            mem_req  <= 1'b1;
                            state    <= REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ERR: begin
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                    mem_err     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule
